// File: rtl/reg_wb_queue.sv
// reg_wb_queue: arbitrates EXU/LSU writeback results into an in-order FIFO draining onto the register-file write port.
// Optional macro REG_WB_FWD_EN adds youngest-match forwarding of queued data to the hazard query ports.
module reg_wb_queue #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exu_valid_in,
    input  logic [ADDR_W-1:0] exu_addr_in,
    input  logic [DATA_W-1:0] exu_data_in,
    output logic              exu_ready_out,
    input  logic              lsu_valid_in,
    input  logic [ADDR_W-1:0] lsu_addr_in,
    input  logic [DATA_W-1:0] lsu_data_in,
    output logic              lsu_ready_out,
    output logic              reg_wr_en_out,
    output logic [ADDR_W-1:0] reg_wr_addr_out,
    output logic [DATA_W-1:0] reg_wr_data_out,
    input  logic [ADDR_W-1:0] rs1_addr_in,
    input  logic [ADDR_W-1:0] rs2_addr_in,
    output logic              rs1_hit_out,
    output logic              rs2_hit_out,
    output logic [DATA_W-1:0] rs1_fwd_data_out,
    output logic [DATA_W-1:0] rs2_fwd_data_out,
    output logic              empty_out
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [PW:0]       count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic              rr_last_q, rr_last_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic              grant_lsu, grant_exu, room, hs, push, pop;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic [DEPTH-1:0]  occ;

    // rr_last_q = 1 means LSU won the previous handshake
    always_comb begin
        grant_lsu = lsu_valid_in && (!exu_valid_in || !rr_last_q);
        grant_exu = exu_valid_in && !grant_lsu;
        room = count_q != FULL;
        exu_ready_out = grant_exu && room;
        lsu_ready_out = grant_lsu && room;
        hs = exu_ready_out || lsu_ready_out;
        in_addr = lsu_ready_out ? lsu_addr_in : exu_addr_in;
        in_data = lsu_ready_out ? lsu_data_in : exu_data_in;
        push = hs && in_addr != '0;
        pop = count_q != '0;
        rr_last_d = hs ? lsu_ready_out : rr_last_q;
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        addr_d = addr_q;
        data_d = data_q;
        if (push) begin
            addr_d[wr_ptr_q] = in_addr;
            data_d[wr_ptr_q] = in_data;
        end
    end

    always_comb begin
        reg_wr_en_out = pop;
        reg_wr_addr_out = pop ? addr_q[rd_ptr_q] : '0;
        reg_wr_data_out = pop ? data_q[rd_ptr_q] : '0;
        empty_out = !pop;
        rs1_hit_out = 1'b0;
        rs2_hit_out = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = {1'b0, PW'(i) - rd_ptr_q} < count_q;
            if (occ[i] && rs1_addr_in != '0 && addr_q[i] == rs1_addr_in) rs1_hit_out = 1'b1;
            if (occ[i] && rs2_addr_in != '0 && addr_q[i] == rs2_addr_in) rs2_hit_out = 1'b1;
        end
    end

`ifdef REG_WB_FWD_EN
    logic [PW-1:0] fwd_idx;

    // walk oldest to youngest so the last match (youngest) wins
    always_comb begin
        rs1_fwd_data_out = '0;
        rs2_fwd_data_out = '0;
        fwd_idx = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PW'(k);
            if ({1'b0, PW'(k)} < count_q && rs1_addr_in != '0 && addr_q[fwd_idx] == rs1_addr_in)
                rs1_fwd_data_out = data_q[fwd_idx];
            if ({1'b0, PW'(k)} < count_q && rs2_addr_in != '0 && addr_q[fwd_idx] == rs2_addr_in)
                rs2_fwd_data_out = data_q[fwd_idx];
        end
    end
`else
    assign rs1_fwd_data_out = '0;
    assign rs2_fwd_data_out = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rr_last_q <= 1'b0;
        end else begin
            count_q <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rr_last_q <= rr_last_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_reg_wb_queue.sv
// tb_reg_wb_queue: directed and randomized checks of reg_wb_queue against a queue-based reference model.
module tb_reg_wb_queue;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          exu_valid_in = 1'b0;
    logic [AW-1:0] exu_addr_in = '0;
    logic [DW-1:0] exu_data_in = '0;
    logic          exu_ready_out;
    logic          lsu_valid_in = 1'b0;
    logic [AW-1:0] lsu_addr_in = '0;
    logic [DW-1:0] lsu_data_in = '0;
    logic          lsu_ready_out;
    logic          reg_wr_en_out;
    logic [AW-1:0] reg_wr_addr_out;
    logic [DW-1:0] reg_wr_data_out;
    logic [AW-1:0] rs1_addr_in = '0;
    logic [AW-1:0] rs2_addr_in = '0;
    logic          rs1_hit_out, rs2_hit_out;
    logic [DW-1:0] rs1_fwd_data_out, rs2_fwd_data_out;
    logic          empty_out;

    always #5 clk = ~clk;

    reg_wb_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .exu_valid_in(exu_valid_in), .exu_addr_in(exu_addr_in), .exu_data_in(exu_data_in),
        .exu_ready_out(exu_ready_out),
        .lsu_valid_in(lsu_valid_in), .lsu_addr_in(lsu_addr_in), .lsu_data_in(lsu_data_in),
        .lsu_ready_out(lsu_ready_out),
        .reg_wr_en_out(reg_wr_en_out), .reg_wr_addr_out(reg_wr_addr_out), .reg_wr_data_out(reg_wr_data_out),
        .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
        .rs1_hit_out(rs1_hit_out), .rs2_hit_out(rs2_hit_out),
        .rs1_fwd_data_out(rs1_fwd_data_out), .rs2_fwd_data_out(rs2_fwd_data_out),
        .empty_out(empty_out)
    );

    ent_t          q[$];
    logic [AW-1:0] acc_log[$];
    bit            last_lsu = 1'b0;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hit(input logic [AW-1:0] rs);
        if (rs == '0) return 1'b0;
        foreach (q[i]) if (q[i].a == rs) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] m_fwd(input logic [AW-1:0] rs);
`ifdef REG_WB_FWD_EN
        if (rs == '0) return '0;
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].a == rs) return q[i].d;
`endif
        return '0;
    endfunction

    // compare all outputs at negedge, then advance the model across the posedge
    task automatic cyc(output bit acc_e, output bit acc_l);
        bit gl, ge, room, ne;
        @(negedge clk);
        gl = lsu_valid_in && (!exu_valid_in || !last_lsu);
        ge = exu_valid_in && !gl;
        room = q.size() < DEPTH;
        ne = q.size() != 0;
        check("exu_ready", 64'(exu_ready_out), 64'(ge && room));
        check("lsu_ready", 64'(lsu_ready_out), 64'(gl && room));
        check("wr_en", 64'(reg_wr_en_out), 64'(ne));
        check("wr_addr", 64'(reg_wr_addr_out), ne ? 64'(q[0].a) : 64'd0);
        check("wr_data", 64'(reg_wr_data_out), ne ? 64'(q[0].d) : 64'd0);
        check("empty", 64'(empty_out), 64'(!ne));
        check("rs1_hit", 64'(rs1_hit_out), 64'(m_hit(rs1_addr_in)));
        check("rs2_hit", 64'(rs2_hit_out), 64'(m_hit(rs2_addr_in)));
        check("rs1_fwd", 64'(rs1_fwd_data_out), 64'(m_fwd(rs1_addr_in)));
        check("rs2_fwd", 64'(rs2_fwd_data_out), 64'(m_fwd(rs2_addr_in)));
        acc_e = ge && room;
        acc_l = gl && room;
        @(posedge clk);
        if (ne) void'(q.pop_front());
        if (acc_e || acc_l) begin
            acc_log.push_back(acc_l ? lsu_addr_in : exu_addr_in);
            if ((acc_l ? lsu_addr_in : exu_addr_in) != '0)
                q.push_back(acc_l ? ent_t'{lsu_addr_in, lsu_data_in} : ent_t'{exu_addr_in, exu_data_in});
            last_lsu = acc_l;
        end
        #1;
    endtask

    initial begin
        bit ae, al;
        int ei, li;
        logic [AW-1:0] exp_order [8];
        logic [DW-1:0] fwd22, fwd11;
        exp_order = '{5'd5, 5'd1, 5'd6, 5'd2, 5'd7, 5'd3, 5'd8, 5'd4};
`ifdef REG_WB_FWD_EN
        fwd11 = 32'h11;
        fwd22 = 32'h22;
`else
        fwd11 = '0;
        fwd22 = '0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_empty", 64'(empty_out), 64'd1);
        check("rst_wr_en", 64'(reg_wr_en_out), 64'd0);
        cyc(ae, al);

        // single write, one-cycle latency
        exu_valid_in = 1'b1; exu_addr_in = 5'd3; exu_data_in = 32'hDEADBEEF;
        #1 check("sw_ready", 64'(exu_ready_out), 64'd1);
        cyc(ae, al);
        exu_valid_in = 1'b0;
        #2;
        check("sw_en", 64'(reg_wr_en_out), 64'd1);
        check("sw_addr", 64'(reg_wr_addr_out), 64'd3);
        check("sw_data", 64'(reg_wr_data_out), 64'hDEADBEEF);
        cyc(ae, al);
        #2 check("sw_empty", 64'(empty_out), 64'd1);

        // writes to x0 are accepted but dropped
        lsu_valid_in = 1'b1; lsu_addr_in = '0; lsu_data_in = 32'h1234; rs1_addr_in = '0;
        #1 check("x0_ready", 64'(lsu_ready_out), 64'd1);
        cyc(ae, al);
        lsu_valid_in = 1'b0;
        #2;
        check("x0_empty", 64'(empty_out), 64'd1);
        check("x0_wr_en", 64'(reg_wr_en_out), 64'd0);
        check("x0_hit", 64'(rs1_hit_out), 64'd0);

        // tie round-robin: LSU wins the first tie after reset
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        last_lsu = 1'b0;
        acc_log.delete();
        ei = 0; li = 0;
        for (int c = 0; c < 20 && (ei < 4 || li < 4); c++) begin
            exu_valid_in = ei < 4; exu_addr_in = AW'(ei + 1); exu_data_in = $urandom;
            lsu_valid_in = li < 4; lsu_addr_in = AW'(li + 5); lsu_data_in = $urandom;
            cyc(ae, al);
            if (ae) ei++;
            if (al) li++;
        end
        exu_valid_in = 1'b0; lsu_valid_in = 1'b0;
        check("tie_done", 64'(ei + li), 64'd8);
        for (int i = 0; i < 8; i++)
            check("tie_order", i < acc_log.size() ? 64'(acc_log[i]) : 64'hFF, 64'(exp_order[i]));
        cyc(ae, al);

        // hazard and forwarding on repeated destination
        rs1_addr_in = 5'd7;
        exu_valid_in = 1'b1; exu_addr_in = 5'd7; exu_data_in = 32'h11;
        cyc(ae, al);
        exu_data_in = 32'h22;
        #2;
        check("hz_hit1", 64'(rs1_hit_out), 64'd1);
        check("hz_fwd1", 64'(rs1_fwd_data_out), 64'(fwd11));
        cyc(ae, al);
        exu_valid_in = 1'b0;
        #2;
        check("hz_hit2", 64'(rs1_hit_out), 64'd1);
        check("hz_fwd2", 64'(rs1_fwd_data_out), 64'(fwd22));
        cyc(ae, al);
        #2 check("hz_clear", 64'(rs1_hit_out), 64'd0);

        // randomized traffic with a mid-stream reset
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                exu_valid_in = 1'b1; exu_addr_in = 5'd9; exu_data_in = $urandom;
                lsu_valid_in = 1'b0;
                cyc(ae, al);
                check("mr_pending", 64'(q.size()), 64'd1);
                rst = 1'b1; exu_valid_in = 1'b0;
                @(posedge clk);
                #1 rst = 1'b0;
                q.delete();
                last_lsu = 1'b0;
                #1;
                check("mr_wr_en", 64'(reg_wr_en_out), 64'd0);
                check("mr_empty", 64'(empty_out), 64'd1);
            end
            if (!exu_valid_in && $urandom_range(0, 1) == 1) begin
                exu_valid_in = 1'b1; exu_addr_in = AW'($urandom_range(0, 7)); exu_data_in = $urandom;
            end
            if (!lsu_valid_in && $urandom_range(0, 1) == 1) begin
                lsu_valid_in = 1'b1; lsu_addr_in = AW'($urandom_range(0, 7)); lsu_data_in = $urandom;
            end
            rs1_addr_in = AW'($urandom_range(0, 7));
            rs2_addr_in = AW'($urandom_range(0, 7));
            cyc(ae, al);
            if (ae) exu_valid_in = 1'b0;
            if (al) lsu_valid_in = 1'b0;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
